// File: rtl/gen_job_sched.sv
// gen_job_sched: queues size/repeat jobs, runs data_gen through its
// ap_start/ap_ready/ap_done handshake "repeat" times per job, counts the
// AXI-stream beats and frames seen on the tap while a job is active and
// reports them per job on a status channel with ready/valid handshake.
module gen_job_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_size,
    input  logic [15:0]     cmd_repeat,
    output logic [31:0]     gen_size,
    output logic            gen_ap_start,
    input  logic            gen_ap_ready,
    input  logic            gen_ap_done,
    input  logic            gen_ap_idle,
    input  logic            mon_tvalid,
    input  logic            mon_tready,
    input  logic            mon_tlast,
    output logic            sts_valid,
    input  logic            sts_ready,
    output logic [ID_W-1:0] sts_id,
    output logic [31:0]     sts_beats,
    output logic [15:0]     sts_frames,
    output logic            busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_REPORT    = 2'd3
    } state_t;

    // command FIFO
    logic [31:0]      fifo_size_r [FIFO_DEPTH];
    logic [15:0]      fifo_rep_r  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             push_s;
    logic             pop_s;
    logic             cmd_ready_r;

    // scheduler state
    state_t           state_r;
    logic [15:0]      rep_r;
    logic [15:0]      run_cnt_r;
    logic [15:0]      run_next_s;
    logic [ID_W-1:0]  next_id_r;
    logic [31:0]      beats_r;
    logic [15:0]      frames_r;
    logic             beat_s;

    // registered outputs
    logic [31:0]      gen_size_r;
    logic             gen_ap_start_r;
    logic             sts_valid_r;
    logic [ID_W-1:0]  sts_id_r;
    logic             busy_r;

    // ap_idle is informational only; the start handshake relies on ap_ready
    logic             unused_idle_s;
    assign unused_idle_s = gen_ap_idle;

    assign push_s     = cmd_valid & cmd_ready_r;
    assign pop_s      = (state_r == S_IDLE) && (count_r != CNT_W'(0));
    assign run_next_s = run_cnt_r + 16'd1;
    assign beat_s     = ((state_r == S_START) || (state_r == S_WAIT_DONE)) &&
                        mon_tvalid && mon_tready;

    assign cmd_ready    = cmd_ready_r;
    assign gen_size     = gen_size_r;
    assign gen_ap_start = gen_ap_start_r;
    assign sts_valid    = sts_valid_r;
    assign sts_id       = sts_id_r;
    assign sts_beats    = beats_r;
    assign sts_frames   = frames_r;
    assign busy         = busy_r;

    // FIFO occupancy after this cycle's push and pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage write (contents are don't-care until pushed)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_size_r[wr_ptr_r] <= cmd_size;
            fifo_rep_r[wr_ptr_r]  <= cmd_repeat;
        end
    end

    // FIFO pointers, occupancy and registered not-full flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s != CNT_W'(FIFO_DEPTH));
        end
    end

    // scheduler FSM with stream monitor and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            rep_r          <= 16'd0;
            run_cnt_r      <= 16'd0;
            next_id_r      <= '0;
            beats_r        <= 32'd0;
            frames_r       <= 16'd0;
            gen_size_r     <= 32'd0;
            gen_ap_start_r <= 1'b0;
            sts_valid_r    <= 1'b0;
            sts_id_r       <= '0;
            busy_r         <= 1'b0;
        end else begin
            busy_r <= (state_r != S_IDLE) || (count_next_s != CNT_W'(0));

            // beats only count while a job is running; saturate, never wrap
            if (beat_s) begin
                if (beats_r != 32'hFFFF_FFFF) begin
                    beats_r <= beats_r + 32'd1;
                end
                if (mon_tlast && (frames_r != 16'hFFFF)) begin
                    frames_r <= frames_r + 16'd1;
                end
            end

            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        sts_id_r  <= next_id_r;
                        next_id_r <= next_id_r + ID_W'(1);
                        rep_r     <= fifo_rep_r[rd_ptr_r];
                        run_cnt_r <= 16'd0;
                        beats_r   <= 32'd0;
                        frames_r  <= 16'd0;
                        busy_r    <= 1'b1;
                        if (fifo_rep_r[rd_ptr_r] == 16'd0) begin
                            sts_valid_r <= 1'b1;
                            state_r     <= S_REPORT;
                        end else begin
                            gen_size_r     <= fifo_size_r[rd_ptr_r];
                            gen_ap_start_r <= 1'b1;
                            state_r        <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (gen_ap_ready) begin
                        if (gen_ap_done) begin
                            // run finished in its own handshake cycle
                            run_cnt_r <= run_next_s;
                            if (run_next_s == rep_r) begin
                                gen_ap_start_r <= 1'b0;
                                sts_valid_r    <= 1'b1;
                                state_r        <= S_REPORT;
                            end else begin
                                // next run is requested straight away
                                gen_ap_start_r <= 1'b1;
                                state_r        <= S_START;
                            end
                        end else begin
                            gen_ap_start_r <= 1'b0;
                            state_r        <= S_WAIT_DONE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (gen_ap_done) begin
                        run_cnt_r <= run_next_s;
                        if (run_next_s == rep_r) begin
                            sts_valid_r <= 1'b1;
                            state_r     <= S_REPORT;
                        end else begin
                            gen_ap_start_r <= 1'b1;
                            state_r        <= S_START;
                        end
                    end
                end
                S_REPORT: begin
                    if (sts_ready) begin
                        sts_valid_r <= 1'b0;
                        busy_r      <= (count_next_s != CNT_W'(0));
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    gen_ap_start_r <= 1'b0;
                    sts_valid_r    <= 1'b0;
                    state_r        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_job_sched.sv
// Scoreboard bench for gen_job_sched: a behavioural data_gen model answers
// the start handshake and emits "size" beats per run; expected job status
// is queued at command push and checked by an independent monitor.
module tb_gen_job_sched;

    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [31:0]     cmd_size = 32'd0;
    logic [15:0]     cmd_repeat = 16'd0;
    logic [31:0]     gen_size;
    logic            gen_ap_start;
    logic            gen_ap_ready = 1'b0;
    logic            gen_ap_done = 1'b0;
    logic            gen_ap_idle = 1'b1;
    logic            mon_tvalid = 1'b0;
    logic            mon_tready = 1'b0;
    logic            mon_tlast = 1'b0;
    logic            sts_valid;
    logic            sts_ready = 1'b1;
    logic [ID_W-1:0] sts_id;
    logic [31:0]     sts_beats;
    logic [15:0]     sts_frames;
    logic            busy;

    always #5 clk = ~clk;

    gen_job_sched #(.FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_size(cmd_size), .cmd_repeat(cmd_repeat),
        .gen_size(gen_size), .gen_ap_start(gen_ap_start),
        .gen_ap_ready(gen_ap_ready), .gen_ap_done(gen_ap_done),
        .gen_ap_idle(gen_ap_idle),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_id(sts_id),
        .sts_beats(sts_beats), .sts_frames(sts_frames), .busy(busy)
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     beats;
        logic [15:0]     frames;
        logic [31:0]     size;
        int              starts;
    } exp_t;

    exp_t            sb_q[$];
    int              checks = 0;
    int              errors = 0;
    logic [ID_W-1:0] exp_id = '0;
    int              cur_starts = 0;
    bit              stall = 1'b0;
    bit              noise = 1'b0;
    int              m_state = 0;
    logic [31:0]     m_left = 32'd0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // data_gen model: drives at posedge+2
    initial begin
        forever begin
            @(posedge clk); #2;
            gen_ap_ready = 1'b0; gen_ap_done = 1'b0;
            mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
            gen_ap_idle = (m_state == 0);
            if (reset) begin
                m_state = 0;
            end else begin
                case (m_state)
                    0: begin
                        if (gen_ap_start) begin
                            if (!stall) begin
                                gen_ap_ready = 1'b1;
                                m_left = gen_size;
                                m_state = 1;
                            end
                        end else if (noise) begin
                            mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
                            gen_ap_done = 1'b1;
                        end
                    end
                    1: begin
                        mon_tvalid = 1'b1; mon_tready = 1'b1;
                        mon_tlast = (m_left == 32'd1);
                        m_left = m_left - 32'd1;
                        if (m_left == 32'd0) m_state = 2;
                    end
                    default: begin
                        gen_ap_done = 1'b1;
                        m_state = 0;
                    end
                endcase
            end
        end
    end

    // monitor: start handshakes and status channel, sampled at negedge
    always @(negedge clk) begin
        if (!reset) begin
            if (gen_ap_start && gen_ap_ready) begin
                if (sb_q.size() == 0) begin
                    chk("start_without_job", 1, 0);
                end else begin
                    chk("gen_size", gen_size, sb_q[0].size);
                    cur_starts++;
                end
            end
            if (sts_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_status", 1, 0);
                end else if (sts_ready) begin
                    chk("sts_id", sts_id, sb_q[0].id);
                    chk("sts_beats", sts_beats, sb_q[0].beats);
                    chk("sts_frames", sts_frames, sb_q[0].frames);
                    chk("start_count", cur_starts, sb_q[0].starts);
                    void'(sb_q.pop_front());
                    cur_starts = 0;
                end else begin
                    chk("stall_id", sts_id, sb_q[0].id);
                    chk("stall_beats", sts_beats, sb_q[0].beats);
                    chk("stall_frames", sts_frames, sb_q[0].frames);
                    chk("stall_no_start", gen_ap_start, 0);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb_q.delete();
        exp_id = '0;
        cur_starts = 0;
    endtask

    task automatic push_cmd(input logic [31:0] size, input logic [15:0] rep, output int waited);
        exp_t e;
        waited = 0;
        cmd_valid = 1'b1; cmd_size = size; cmd_repeat = rep;
        while (!cmd_ready && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 1000) chk("push_timeout", waited, 0);
        e.id = exp_id; e.beats = size * rep; e.frames = rep;
        e.size = size; e.starts = rep;
        exp_id = exp_id + 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", (n >= 3000), 0);
    endtask

    initial begin
        int w;
        int wsum;
        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_gen_ap_start", gen_ap_start, 0);
        chk("rst_sts_valid", sts_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_gen_size", gen_size, 0);
        chk("rst_sts_beats", sts_beats, 0);
        chk("rst_sts_frames", sts_frames, 0);
        chk("rst_sts_id", sts_id, 0);

        // single job with latency check
        push_cmd(32'd16, 16'd1, w);
        @(negedge clk);
        chk("lat_start_n1", gen_ap_start, 0);
        chk("lat_busy_n1", busy, 1);
        @(negedge clk);
        chk("lat_start_n2", gen_ap_start, 1);
        wait_drain();

        // repeated job
        do_reset();
        push_cmd(32'd8, 16'd3, w);
        wait_drain();

        // queue fill while first job stalls on ap_ready
        do_reset();
        stall = 1'b1;
        wsum = 0;
        push_cmd(32'd3, 16'd1, w); wsum += w;
        push_cmd(32'd5, 16'd2, w); wsum += w;
        push_cmd(32'd2, 16'd1, w); wsum += w;
        push_cmd(32'd7, 16'd1, w); wsum += w;
        push_cmd(32'd1, 16'd3, w); wsum += w;
        chk("fill_no_wait", wsum, 0);
        @(negedge clk);
        chk("fill_cmd_ready", cmd_ready, 0);
        chk("fill_busy", busy, 1);
        chk("fill_start_held", gen_ap_start, 1);
        repeat (5) @(posedge clk);
        #1 stall = 1'b0;
        wait_drain();

        // repeat=0 job followed by a normal one, with stray traffic
        do_reset();
        noise = 1'b1;
        push_cmd(32'd9, 16'd0, w);
        push_cmd(32'd4, 16'd1, w);
        wait_drain();

        // status backpressure, then ID wrap
        do_reset();
        sts_ready = 1'b0;
        push_cmd(32'd2, 16'd1, w);
        push_cmd(32'd3, 16'd1, w);
        begin
            int n = 0;
            while (!sts_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk("bp_sts_timeout", (n >= 200), 0);
        end
        repeat (10) @(posedge clk);
        #1 sts_ready = 1'b1;
        wait_drain();
        for (int i = 0; i < 14; i++) push_cmd(32'd5, 16'd0, w);
        push_cmd(32'd1, 16'd1, w);
        wait_drain();
        noise = 1'b0;

        // reset while waiting for ap_done with two jobs queued
        do_reset();
        push_cmd(32'd20, 16'd1, w);
        push_cmd(32'd5, 16'd1, w);
        push_cmd(32'd6, 16'd1, w);
        repeat (5) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("mid_rst_start", gen_ap_start, 0);
        chk("mid_rst_sts_valid", sts_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        push_cmd(32'd4, 16'd1, w);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gen_job_sched.md
Name: gen_job_sched

Overview:
- Job scheduler that sequences one data_gen instance through its ap_start/ap_ready/ap_done handshake.
- Queues size/repeat commands in a small FIFO and launches data_gen repeat times per job with the given size.
- Monitors the data_gen AXI-stream output and reports beats/frames per completed job on a status channel.
- Sits between the host/test control path and data_gen; data_gen's stream output goes unchanged to its consumer.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2
ID_W, 4, width of the job ID; wraps modulo 2^ID_W

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command FIFO not full
cmd_size  input  32  size passed to data_gen
cmd_repeat  input  16  number of data_gen runs for this job
gen_size  output  32  to data_gen size
gen_ap_start  output  1  to data_gen ap_start
gen_ap_ready  input  1  from data_gen ap_ready
gen_ap_done  input  1  from data_gen ap_done
gen_ap_idle  input  1  from data_gen ap_idle
mon_tvalid  input  1  tap of data_gen tvalid
mon_tready  input  1  tap of consumer tready
mon_tlast  input  1  tap of data_gen tlast
sts_valid  output  1  job status valid
sts_ready  input  1  status accepted
sts_id  output  ID_W  job ID
sts_beats  output  32  stream beats transferred during the job
sts_frames  output  16  tlast beats transferred during the job
busy  output  1  FSM not IDLE, or FIFO not empty

Behaviour:
- Reset values: all outputs registered and 0 after reset, except cmd_ready, which is 1. Reset clears the FIFO, the job-ID counter, run/beat/frame counters and the FSM (IDLE).
- Reset mid-job: gen_ap_start drops on the next edge. The interrupted job is lost and no status is produced for it.
- Command push: occurs on cmd_valid & cmd_ready. cmd_ready = !full. A push and a pop in the same cycle are both performed.
- The job ID is assigned at pop, starting at 0 and incrementing per popped job, wrapping modulo 2^ID_W.
- FSM states: IDLE, START, WAIT_DONE, REPORT.
- IDLE, FIFO non-empty: pop and latch size, repeat and id; clear the counters.
  - repeat==0: go to REPORT directly with beats=frames=0 and no start issued.
  - Otherwise: load gen_size, go to START.
- START: gen_ap_start=1 and held until a cycle with gen_ap_ready=1. That cycle is the accepted handshake; gen_ap_start=0 from the next cycle. Go to WAIT_DONE.
  - If gen_ap_done is also 1 in the handshake cycle, it counts as done for that run.
- WAIT_DONE: on gen_ap_done=1, increment the run count.
  - If run count == repeat: go to REPORT.
  - Otherwise: go to START, with gen_ap_start high on the next cycle.
- REPORT: sts_valid=1. sts_id/sts_beats/sts_frames are stable while sts_valid=1 and sts_ready=0. On sts_valid & sts_ready, go to IDLE. The next pop can occur in that following IDLE cycle. Status backpressure stalls scheduling.
- gen_size stays constant from job load until REPORT exits.
- Latency: with the FSM in IDLE and the FIFO empty, a push in cycle N is popped in N+1 and gen_ap_start rises in N+2.
- Monitor:
  - In START and WAIT_DONE, each cycle with mon_tvalid & mon_tready increments beats (saturating at 2^32-1).
  - If mon_tlast is also high in that cycle, frames increments as well (saturating at 2^16-1).
  - Beats seen in IDLE and REPORT are ignored.
- gen_ap_idle is status only. If gen_ap_idle=0 in IDLE, the scheduler still waits for gen_ap_ready before the start handshake completes.
- Spurious gen_ap_done in IDLE, START (without handshake) or REPORT is ignored.
- Widths: the run counter is 16 bits and compares against cmd_repeat exactly. cmd_repeat=65535 is legal.

Test Plan:
- Single job, size=16, repeat=1: data_gen model gives 16 beats with tlast on beat 16 -> exactly one gen_ap_start handshake, gen_size=16 throughout; status id=0, beats=16, frames=1.
- Repeat job, size=8, repeat=3: -> three start handshakes, each after the previous ap_done; status beats=24, frames=3, id=0.
- Queue fill, FIFO_DEPTH=4: push 5 commands back-to-back while the first job is stalled on gen_ap_ready=0 -> cmd_ready=0 only when 4 entries are queued; all jobs complete in order with ids 0..4.
- repeat=0 command, then size=4, repeat=1 -> first status beats=0, frames=0 with no gen_ap_start pulse; second status id=1, beats=4.
- Status backpressure: hold sts_ready=0 for 10 cycles with 2 jobs queued -> sts fields stable, no gen_ap_start for job 2 until the status handshake; ID wraps to 0 after job 15 (ID_W=4).
- Reset asserted in WAIT_DONE with 2 queued -> next cycle gen_ap_start=0, sts_valid=0, busy=0, cmd_ready=1; the next pushed job reports id=0.
